// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of an asynchronous input over a fixed
// gate window of clk cycles and reports the result in Hz, saturating at MAXSPEED.
`timescale 1ns/1ps

module freq_meter #(
    parameter int BASESPEED = 50000000,
    parameter int GATE_HZ   = 10,
    parameter int MAXSPEED  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sigIn,
    output logic [19:0] speed,
    output logic        valid,
    output logic        overRange
);

    localparam int GATE_LEN = BASESPEED / GATE_HZ;
    localparam int GW       = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;
    localparam int PW       = 40;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic          prev;
    logic          edge_strobe;
    logic [GW-1:0] gate_cnt;
    logic [19:0]   edge_cnt;
    logic [19:0]   edges_total;
    logic          window_close;
    logic [PW-1:0] product;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, which makes the chain a
    // real shift register rather than a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= sigIn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign edge_strobe  = sync2 & ~prev;
    assign window_close = enable && (gate_cnt == GATE_LAST);

    // Count including a strobe on this cycle, so an edge in the final gate
    // cycle lands in the closing window; all-ones is sticky.
    assign edges_total = (edge_strobe && !(&edge_cnt)) ? edge_cnt + 20'd1 : edge_cnt;
    assign product     = PW'(edges_total) * PW'(GATE_HZ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (!enable || (gate_cnt == GATE_LAST)) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edges_total;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed     <= '0;
            valid     <= 1'b0;
            overRange <= 1'b0;
        end else begin
            valid <= window_close;
            if (window_close) begin
                if (product > PW'(MAXSPEED)) begin
                    speed     <= 20'(MAXSPEED);
                    overRange <= 1'b1;
                end else begin
                    speed     <= product[19:0];
                    overRange <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: table-driven periodic inputs, hand-built
// corner sequences, and randomized input against a window-level edge-count model.
`timescale 1ns/1ps

module tb_freq_meter;

    localparam int BASESPEED = 1000;
    localparam int GATE_HZ   = 10;
    localparam int MAXSPEED  = 200;
    localparam int GATE_LEN  = BASESPEED / GATE_HZ;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        sig_in;
    logic [19:0] speed;
    logic        valid;
    logic        over_range;

    int checks;
    int errors;

    freq_meter #(
        .BASESPEED(BASESPEED),
        .GATE_HZ  (GATE_HZ),
        .MAXSPEED (MAXSPEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sigIn    (sig_in),
        .speed    (speed),
        .valid    (valid),
        .overRange(over_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Square-wave generator; drives sig_in at negedges while gen_on is set.
    bit gen_on;
    int gen_period;
    int gen_phase;

    initial begin
        gen_on     = 1'b0;
        gen_period = 0;
        gen_phase  = 0;
        forever begin
            @(negedge clk);
            if (gen_on) begin
                sig_in = (gen_period != 0) && (gen_phase < gen_period / 2);
                if (gen_period != 0)
                    gen_phase = (gen_phase + 1 == gen_period) ? 0 : gen_phase + 1;
            end
        end
    end

    task automatic set_gen(input int period, input bit on);
        @(posedge clk);
        gen_period = period;
        gen_phase  = 0;
        gen_on     = on;
    endtask

    // Reference model: every input rise seen at a clock edge is credited to the
    // window covering the edge two cycles later; each window of GATE_LEN
    // enabled cycles reports min(rises * GATE_HZ, MAXSPEED).
    int unsigned m_edge;
    int unsigned m_pos;
    int unsigned m_start;
    bit          m_last;
    int unsigned rise_q[$];
    int          exp_speed;
    int          exp_valid;
    int          exp_over;
    bit          chk_on;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last = 1'b0;
            m_pos  = 0;
            rise_q.delete();
            exp_speed = 0;
            exp_valid = 0;
            exp_over  = 0;
        end else begin
            int n;
            int hz;
            m_edge++;
            exp_valid = 0;
            if (enable) begin
                if (m_pos == 0) m_start = m_edge;
                if (m_pos == GATE_LEN - 1) begin
                    n = 0;
                    while (rise_q.size() > 0 && rise_q[0] <= m_edge) begin
                        if (rise_q[0] >= m_start) n++;
                        void'(rise_q.pop_front());
                    end
                    hz        = n * GATE_HZ;
                    exp_valid = 1;
                    exp_over  = (hz > MAXSPEED) ? 1 : 0;
                    exp_speed = (hz > MAXSPEED) ? MAXSPEED : hz;
                    m_pos     = 0;
                end else begin
                    m_pos++;
                end
            end else begin
                m_pos = 0;
            end
            if (sig_in && !m_last) rise_q.push_back(m_edge + 2);
            m_last = sig_in;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_valid", int'(valid), exp_valid);
            check("model_speed", int'(speed), exp_speed);
            check("model_over", int'(over_range), exp_over);
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (valid !== 1'b1 && n < 300);
    endtask

    typedef struct {
        int period;
        int exp_speed;
        int exp_over;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int hold;

        vecs[0] = '{period: 0,  exp_speed: 0,   exp_over: 0};
        vecs[1] = '{period: 10, exp_speed: 100, exp_over: 0};
        vecs[2] = '{period: 5,  exp_speed: 200, exp_over: 0};
        vecs[3] = '{period: 4,  exp_speed: 200, exp_over: 1};
        vecs[4] = '{period: 20, exp_speed: 50,  exp_over: 0};
        vecs[5] = '{period: 2,  exp_speed: 200, exp_over: 1};

        checks = 0;
        errors = 0;
        chk_on = 1'b0;
        rst    = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;

        #1;
        check("reset_speed", int'(speed), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_over", int'(over_range), 0);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_on = 1'b1;

        // First valid latency and repetition, period 10.
        set_gen(10, 1'b1);
        repeat (20) @(negedge clk);
        enable = 1'b1;
        wait_valid(n);
        check("first_valid_latency", n, GATE_LEN);
        check("first_speed", int'(speed), 100);
        check("first_over", int'(over_range), 0);
        wait_valid(n);
        check("second_valid_spacing", n, GATE_LEN);
        @(negedge clk);
        check("valid_one_cycle", int'(valid), 0);

        // Table of periodic inputs.
        foreach (vecs[i]) begin
            set_gen(vecs[i].period, 1'b1);
            wait_valid(n);
            wait_valid(n);
            check($sformatf("row%0d_spacing", i), n, GATE_LEN);
            check($sformatf("row%0d_speed", i), int'(speed), vecs[i].exp_speed);
            check($sformatf("row%0d_over", i), int'(over_range), vecs[i].exp_over);
        end

        // enable dropped at gate cycle 50 for 30 cycles.
        set_gen(10, 1'b1);
        wait_valid(n);
        wait_valid(n);
        check("pre_gap_speed", int'(speed), 100);
        repeat (50) @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("gap_no_valid", int'(valid), 0);
            check("gap_speed_hold", int'(speed), 100);
        end
        enable = 1'b1;
        wait_valid(n);
        check("reenable_latency", n, GATE_LEN);
        check("reenable_speed", int'(speed), 100);

        // Single edge placed on the last gate cycle, then one cycle later.
        set_gen(0, 1'b0);
        @(negedge clk);
        sig_in = 1'b0;
        enable = 1'b0;
        for (int shift = 0; shift < 2; shift++) begin
            repeat (10) @(negedge clk);
            enable = 1'b1;
            for (int k = 1; k <= GATE_LEN; k++) begin
                @(negedge clk);
                if (k == 97 + shift) sig_in = 1'b1;
            end
            check($sformatf("last_cycle_s%0d_valid", shift), int'(valid), 1);
            check($sformatf("last_cycle_s%0d_win1", shift), int'(speed), (shift == 0) ? 10 : 0);
            wait_valid(n);
            check($sformatf("last_cycle_s%0d_win2", shift), int'(speed), (shift == 0) ? 0 : 10);
            sig_in = 1'b0;
            enable = 1'b0;
        end

        // Asynchronous reset mid-window, then input high at release.
        set_gen(10, 1'b1);
        @(negedge clk);
        enable = 1'b1;
        wait_valid(n);
        wait_valid(n);
        check("pre_reset_speed", int'(speed), 100);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_speed", int'(speed), 0);
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_over", int'(over_range), 0);
        gen_on = 1'b0;
        sig_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= GATE_LEN; j++) begin
            @(negedge clk);
            if (j == GATE_LEN) begin
                check("release_window_valid", int'(valid), 1);
                check("release_window_speed", int'(speed), 110);
            end
            sig_in = ((j + 4) % 10) < 5;
        end

        // Randomized input and enable, checked every cycle by the model.
        hold = 0;
        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                sig_in = ~sig_in;
                hold   = (c < 800) ? $urandom_range(0, 3) : $urandom_range(2, 12);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 249) == 0) enable = ~enable;
        end

        enable = 1'b0;
        repeat (5) @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
